// File: rtl/num_entry_debounce.sv
// Two-button number entry: synchronize, debounce and step two 4-bit operand nibbles.
// Optional auto-repeat on long holds is enabled by defining NUM_ENTRY_AUTOREPEAT_EN.
module num_entry_debounce #(
  parameter int unsigned DB_CNT     = 4,
  parameter int unsigned HOLD_TICKS = 64,
  parameter int unsigned REP_TICKS  = 16
) (
  input  logic       clk,
  input  logic       RSTN,
  input  logic       tick,
  input  logic [1:0] btn,
  input  logic       down,
  output logic [7:0] num,
  output logic [1:0] btn_pulse,
  output logic [1:0] btn_level
);

  typedef enum logic [1:0] {REL, REL_CHK, PRS, PRS_CHK} db_state_e;

  localparam logic [3:0] DB_LIM = 4'(DB_CNT);

  logic [1:0] sync1_q, sync2_q;
  logic [1:0] step;
  logic [7:0] num_q, num_d;
  logic [1:0] pulse_q, pulse_d;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    db_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       press;
    logic       s;

    assign s = sync2_q[gi];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press   = 1'b0;
      if (tick) begin
        case (state_q)
          REL: begin
            if (s) begin
              if (DB_LIM == 4'd1) begin
                state_d = PRS;
                press   = 1'b1;
              end else begin
                state_d = REL_CHK;
                cnt_d   = 4'd1;
              end
            end
          end
          REL_CHK: begin
            if (!s) begin
              state_d = REL;
              cnt_d   = 4'd0;
            end else if (cnt_q + 4'd1 == DB_LIM) begin
              state_d = PRS;
              cnt_d   = 4'd0;
              press   = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          PRS: begin
            // With a one-sample debounce the release qualifies on its first sample.
            if (!s) begin
              if (DB_LIM == 4'd1) begin
                state_d = REL;
              end else begin
                state_d = PRS_CHK;
                cnt_d   = 4'd1;
              end
            end
          end
          PRS_CHK: begin
            if (s) begin
              state_d = PRS;
              cnt_d   = 4'd0;
            end else if (cnt_q + 4'd1 == DB_LIM) begin
              state_d = REL;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          default: begin
            state_d = REL;
            cnt_d   = 4'd0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
        state_q <= REL;
        cnt_q   <= 4'd0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign btn_level[gi] = (state_q == PRS) || (state_q == PRS_CHK);

`ifdef NUM_ENTRY_AUTOREPEAT_EN
    localparam logic [15:0] HOLD_LIM = 16'(HOLD_TICKS);
    localparam logic [15:0] REP_LIM  = 16'(REP_TICKS);

    logic [15:0] hold_q, hold_d;
    logic        rep_q, rep_d;
    logic        repeat_step;
    logic        pressed_next;

    assign pressed_next = (state_d == PRS) || (state_d == PRS_CHK);

    // hold counts ticks since the last step; rep selects the initial or repeat interval.
    always_comb begin
      hold_d      = hold_q;
      rep_d       = rep_q;
      repeat_step = 1'b0;
      if (!pressed_next || press) begin
        hold_d = 16'd0;
        rep_d  = 1'b0;
      end else if (tick) begin
        if (hold_q + 16'd1 == (rep_q ? REP_LIM : HOLD_LIM)) begin
          repeat_step = 1'b1;
          hold_d      = 16'd0;
          rep_d       = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
    end

    always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
        hold_q <= 16'd0;
        rep_q  <= 1'b0;
      end else begin
        hold_q <= hold_d;
        rep_q  <= rep_d;
      end
    end

    assign step[gi] = press | repeat_step;
`else
    assign step[gi] = press;
`endif
  end

  // Nibbles wrap independently; no carry or borrow crosses between A and B.
  always_comb begin
    num_d   = num_q;
    pulse_d = step;
    for (int i = 0; i < 2; i++) begin
      if (step[i]) begin
        num_d[4*i +: 4] = down ? (num_q[4*i +: 4] - 4'd1) : (num_q[4*i +: 4] + 4'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      num_q   <= 8'h00;
      pulse_q <= 2'b00;
    end else begin
      num_q   <= num_d;
      pulse_q <= pulse_d;
    end
  end

  assign num       = num_q;
  assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_num_entry_debounce.sv
// Bench for num_entry_debounce: directed vector table, reset/pulse corner sequences,
// and randomized stimulus against a run-length reference model.
module tb_num_entry_debounce;

  localparam int DB = 4;
`ifdef NUM_ENTRY_AUTOREPEAT_EN
  localparam int HOLD = 64;
  localparam int REP  = 16;
`endif

  logic       clk = 1'b0;
  logic       RSTN;
  logic       tick;
  logic [1:0] btn;
  logic       down;
  logic [7:0] num;
  logic [1:0] btn_pulse;
  logic [1:0] btn_level;

  always #5 clk = ~clk;

  num_entry_debounce #(.DB_CNT(DB)) dut (
    .clk       (clk),
    .RSTN      (RSTN),
    .tick      (tick),
    .btn       (btn),
    .down      (down),
    .num       (num),
    .btn_pulse (btn_pulse),
    .btn_level (btn_level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: level per button flips after DB consecutive disagreeing samples.
  int       nib[2];
  bit       lvl[2];
  int       run[2];
`ifdef NUM_ENTRY_AUTOREPEAT_EN
  int       held[2];
`endif
  bit [1:0] exp_pulse;
  bit [1:0] hist[2];

  typedef struct {
    logic [1:0] b;
    logic       d;
    int         n;
    logic [7:0] e_num;
    logic [1:0] e_lvl;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      nib[i] = 0;
      lvl[i] = 1'b0;
      run[i] = 0;
`ifdef NUM_ENTRY_AUTOREPEAT_EN
      held[i] = 0;
`endif
      hist[i] = 2'b00;
    end
    exp_pulse = 2'b00;
  endtask

  task automatic model_edge();
    bit [1:0] p;
    p = 2'b00;
    for (int i = 0; i < 2; i++) begin
      bit s;
      bit stepped;
      bit just;
      s       = hist[1][i];
      stepped = 1'b0;
      just    = 1'b0;
      if (tick) begin
        if (s != lvl[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            lvl[i] = s;
            run[i] = 0;
            if (s) begin
              stepped = 1'b1;
              just    = 1'b1;
`ifdef NUM_ENTRY_AUTOREPEAT_EN
              held[i] = 0;
`endif
            end
          end
        end else begin
          run[i] = 0;
        end
`ifdef NUM_ENTRY_AUTOREPEAT_EN
        if (lvl[i] && !just) begin
          held[i]++;
          if (held[i] >= HOLD && ((held[i] - HOLD) % REP) == 0) stepped = 1'b1;
        end
`endif
      end
      if (stepped) begin
        nib[i] = (nib[i] + (down ? 15 : 1)) % 16;
        p[i]   = 1'b1;
      end
    end
    exp_pulse = p;
    hist[1]   = hist[0];
    hist[0]   = btn;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!RSTN) model_reset();
    else model_edge();
    #1;
    check("model_num", int'(num), nib[1] * 16 + nib[0]);
    check("model_pulse", int'(btn_pulse), int'(exp_pulse));
    check("model_level", int'(btn_level), int'({lvl[1], lvl[0]}));
  endtask

  task automatic async_reset(input string name);
    RSTN = 1'b0;
    #1;
    check({name, "_num"}, int'(num), 0);
    check({name, "_level"}, int'(btn_level), 0);
    check({name, "_pulse"}, int'(btn_pulse), 0);
    model_reset();
    cyc();
    RSTN = 1'b1;
  endtask

  initial begin
    vt[0]  = '{2'b01, 1'b0, 6, 8'h01, 2'b01};
    vt[1]  = '{2'b00, 1'b0, 6, 8'h01, 2'b00};
    vt[2]  = '{2'b10, 1'b0, 3, 8'h01, 2'b00};
    vt[3]  = '{2'b00, 1'b0, 1, 8'h01, 2'b00};
    vt[4]  = '{2'b10, 1'b0, 2, 8'h01, 2'b00};
    vt[5]  = '{2'b00, 1'b0, 6, 8'h01, 2'b00};
    vt[6]  = '{2'b11, 1'b0, 6, 8'h12, 2'b11};
    vt[7]  = '{2'b00, 1'b0, 6, 8'h12, 2'b00};
    vt[8]  = '{2'b11, 1'b1, 6, 8'h01, 2'b11};
    vt[9]  = '{2'b00, 1'b1, 6, 8'h01, 2'b00};
    vt[10] = '{2'b11, 1'b1, 6, 8'hF0, 2'b11};
    vt[11] = '{2'b00, 1'b1, 6, 8'hF0, 2'b00};
    vt[12] = '{2'b01, 1'b1, 6, 8'hFF, 2'b01};
    vt[13] = '{2'b00, 1'b0, 6, 8'hFF, 2'b00};
    vt[14] = '{2'b11, 1'b0, 6, 8'h00, 2'b11};
    vt[15] = '{2'b00, 1'b0, 6, 8'h00, 2'b00};

    RSTN = 1'b1;
    tick = 1'b0;
    btn  = 2'b00;
    down = 1'b0;
    model_reset();
    #2;
    RSTN = 1'b0;
    #1;
    check("reset_num", int'(num), 0);
    check("reset_pulse", int'(btn_pulse), 0);
    check("reset_level", int'(btn_level), 0);
    repeat (2) cyc();
    RSTN = 1'b1;
    tick = 1'b1;

    // Directed table with a sample on every clock.
    for (int k = 0; k < 16; k++) begin
      btn  = vt[k].b;
      down = vt[k].d;
      repeat (vt[k].n) cyc();
      check($sformatf("tbl%0d_num", k), int'(num), int'(vt[k].e_num));
      check($sformatf("tbl%0d_level", k), int'(btn_level), int'(vt[k].e_lvl));
      $display("row %0d btn=%b down=%b cycles=%0d num=%h level=%b", k, vt[k].b, vt[k].d,
               vt[k].n, num, btn_level);
    end

    // Press in progress is discarded by reset; held button must re-qualify.
    btn = 2'b01;
    repeat (6) cyc();
    btn = 2'b00;
    repeat (6) cyc();
    check("pre_rst_num", int'(num), 8'h01);
    btn = 2'b01;
    repeat (4) cyc();
    async_reset("midcount_rst");
    repeat (5) cyc();
    check("requal_early_num", int'(num), 8'h00);
    cyc();
    check("requal_num", int'(num), 8'h01);
    check("pulse_first", int'(btn_pulse), 2'b01);
    check("level_same_edge", int'(btn_level), 2'b01);
    cyc();
    check("pulse_gone", int'(btn_pulse), 2'b00);
    btn = 2'b00;
    repeat (6) cyc();
    $display("reset-midcount sequence num=%h", num);

    // Long hold on btn[1]: auto-repeat steps only when enabled.
    btn = 2'b10;
    repeat (102) cyc();
`ifdef NUM_ENTRY_AUTOREPEAT_EN
    check("long_hold_num", int'(num), 8'h41);
`else
    check("long_hold_num", int'(num), 8'h11);
`endif
    btn = 2'b00;
    repeat (6) cyc();
    check("long_hold_release", int'(btn_level), 2'b00);
    $display("long-hold sequence num=%h", num);

    // Randomized segments with varying tick density and bounce rate.
    for (int seg = 0; seg < 8; seg++) begin
      int tick_mode;
      int flip_rate;
      tick_mode = $urandom_range(0, 2);
      flip_rate = (seg % 2 == 0) ? 40 : 6;
      for (int c = 0; c < 500; c++) begin
        case (tick_mode)
          0:       tick = 1'b1;
          1:       tick = ($urandom_range(0, 3) == 0);
          default: tick = ($urandom_range(0, 1) == 0);
        endcase
        for (int i = 0; i < 2; i++)
          if ($urandom_range(0, flip_rate - 1) == 0) btn[i] = ~btn[i];
        if ($urandom_range(0, 49) == 0) down = ~down;
        if ($urandom_range(0, 1499) == 0) async_reset("rand_rst");
        cyc();
      end
      $display("segment %0d tick_mode=%0d num=%h level=%b", seg, tick_mode, num, btn_level);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/num_entry_debounce.md
# num_entry_debounce

Upstream number-entry stage for the 4-bit adder display path: debounces two raw push-buttons and steps two 4-bit operand nibbles, presenting them as one 8-bit `num` bus. The adder takes `num[3:0]` as A and `num[7:4]` as B, and the display mux scans the same bus. It replaces the undebounced button counter, runs on the board clock, and uses a divided-clock strobe as its sampling tick.

## Interface
- `DB_CNT`, default 4: consecutive equal tick-samples required to accept a new button level (1..15).
- `HOLD_TICKS`, default 64: ticks a press must be held before auto-repeat starts (only with `AUTOREPEAT_EN`).
- `REP_TICKS`, default 16: ticks between auto-repeat steps (only with `AUTOREPEAT_EN`).
- `clk  in  1`: board clock; every flop uses its rising edge.
- `RSTN  in  1`: asynchronous, active-low reset.
- `tick  in  1`: sample strobe, one `clk` cycle wide, generated from the clock divider.
- `btn  in  2`: raw, asynchronous, active-high buttons; `btn[0]` steps the low nibble, `btn[1]` steps the high nibble.
- `down  in  1`: 0 = increment, 1 = decrement; sampled at the step edge.
- `num  out  8`: operand pair; `[3:0]` = A, `[7:4]` = B.
- `btn_pulse  out  2`: one-cycle strobe per nibble step.
- `btn_level  out  2`: debounced button levels.

## Operation
- Each `btn` bit passes through a 2-flop synchronizer clocked every `clk`. Debounce logic sees only the synchronized value `s[i]`.
- Each button has an independent debounce FSM with a 4-bit stable counter `cnt`. The FSM updates only in cycles where `tick` = 1.
  - REL (released): `s` = 1 → REL_CHK with `cnt` = 1. If `DB_CNT` = 1, go directly to PRS and raise the press event.
  - REL_CHK: `s` = 1 → `cnt`+1; when `cnt` reaches `DB_CNT` → PRS and raise the press event. `s` = 0 → REL with `cnt` = 0.
  - PRS (pressed): `s` = 0 → PRS_CHK with `cnt` = 1.
  - PRS_CHK: `s` = 0 → `cnt`+1; when `cnt` reaches `DB_CNT` → REL, with no event. `s` = 1 → PRS with `cnt` = 0.
- `btn_level[i]` = 1 in PRS and PRS_CHK.
- A press event steps nibble i: +1 mod 16 when `down` = 0, −1 mod 16 when `down` = 1. Wrap-around: F+1 = 0 and 0−1 = F, with no carry into the other nibble.
- Both nibbles step independently. Simultaneous events in the same cycle update both nibbles and assert both pulse bits.
- Glitches shorter than `DB_CNT` ticks produce no step and no level change.
- `tick` held high continuously is legal: every `clk` then counts as a sample.

## Timing
- Reset values: `num` = 8'h00, `btn_pulse` = 2'b00, `btn_level` = 2'b00, all FSMs in REL, all counters 0, synchronizers 0.
- Reset applies immediately and asynchronously. A press in progress is discarded. After release of `RSTN`, a still-held button must be re-qualified through the full `DB_CNT` sequence before it produces a step.
- The nibble update and the debounced level change occur on the same `clk` edge as the qualifying tick.
- `btn_pulse[i]` is registered and is high for exactly the one cycle following that edge.
- Worst-case press latency from a stable raw edge: 2 `clk` cycles plus `DB_CNT` ticks.
- Release produces no pulse.
- `num` is stable between steps and is safe for the display scan to sample at any time.

## Configuration
- `NUM_ENTRY_AUTOREPEAT_EN` defined: per-button hold counter.
  - While in PRS or PRS_CHK, after `HOLD_TICKS` ticks from the press event, one step is generated and then one step every `REP_TICKS` ticks until the FSM leaves the pressed states.
  - Each repeat step pulses `btn_pulse`.
  - Hold counters clear on release and on reset.
- Not defined: exactly one step per qualified press; no hold counters are synthesized; `HOLD_TICKS` and `REP_TICKS` are ignored.

## Test plan
- Reset mid-count: hold `btn[0]` for 2 ticks, pulse `RSTN` low → `num` = 00 immediately, `btn_level` = 00. Keep holding → step occurs only after 4 further ticks, giving `num` = 01.
- Clean press: hold `btn[0]` high for 4 ticks with `down` = 0 → `num` = 01. `btn_pulse` = 01 for exactly one cycle. `btn_level[0]` = 1 from the same edge.
- Bounce rejection: toggle `btn[1]` high 3 ticks, low 1, high 2, low → `num` = 00 and `btn_pulse` never asserted.
- Wrap-around: 15 clean presses of `btn[1]` → `num` = F0. One more → `num` = 00. Then `down` = 1 and press `btn[0]` → `num` = 0F.
- Simultaneous: both buttons rise on the same cycle and are held 4 ticks → `num` 00 → 11 and `btn_pulse` = 11 for one cycle.
- With `NUM_ENTRY_AUTOREPEAT_EN`: hold `btn[0]` for 4 + 64 + 32 ticks → steps at tick 4, 68, 84 and 100, giving `num` = 04. Without the macro → `num` = 01.
